// File: rtl/seq_pattern_detector_pkg.sv
// Shared defaults and mode encodings for the serial pattern detector and its
// status counters.
package seq_pattern_detector_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_LEN_W   = 4;

    localparam logic SEQ_MODE_OVL  = 1'b1;
    localparam logic SEQ_MODE_NOVL = 1'b0;

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clear beats increment.
// Shared by the detector and other status counters.
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: runtime-loadable pattern of 1..MAX_LEN bits,
// overlapping or non-overlapping matching, registered match pulse and count.
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_ovf
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic [MAX_LEN-1:0] mask;

    // Only the newest len bits take part in the compare.
    assign mask = ~({MAX_LEN{1'b1}} << len_q);

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pat;
            ovl_d  = cfg_ovl;
            hist_d = '0;
            fill_d = '0;
            if (cfg_len == '0) begin
                len_d = LEN_W'(1);
            end else if (cfg_len > LEN_MAX) begin
                len_d = LEN_MAX;
            end else begin
                len_d = cfg_len;
            end
        end else if (in_valid) begin
            hist_d = {hist_q[MAX_LEN-2:0], x};
            fill_d = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + 1'b1;
            if ((fill_d >= len_q) && (((hist_d ^ pat_q) & mask) == '0)) begin
                match_d = 1'b1;
                // Non-overlapping mode demands len fresh bits before the next hit.
                if (ovl_q == SEQ_MODE_NOVL) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= '0;
            len_q   <= LEN_MAX;
            ovl_q   <= SEQ_MODE_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    seq_sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (match_d),
        .clr_i (cnt_clr),
        .cnt_o (match_cnt),
        .ovf_o (cnt_ovf)
    );

    assign match = match_q;

endmodule
